// File: rtl/dbus_responder.sv
// dbus_responder: single-port data-bus target backed by a 2^DEPTH_LOG2 x 64-bit
// word store. Captures one request, waits LATENCY cycles, answers with a
// one-cycle addr_ok/data_ok pulse and the full aligned word (post-write value
// for writes). Out-of-range accesses read zero and drop writes.
// Optional build macro: DBUS_RESPONDER_STALL_EN adds 0..3 pseudo-random extra
// wait cycles per request, drawn from an 8-bit LFSR.

package dbus_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;
    // LATENCY-1 (<=14) plus up to 3 stall cycles fits in 5 bits
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        addr_q;
    logic [2:0]         size_q;
    logic [7:0]         strobe_q;
    logic [63:0]        data_q;

    logic [63:0]        mem [0:DEPTH-1];

    logic [63:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic [63:0]           old_word;
    logic [63:0]           merged_word;
    logic [63:0]           rdata_c;
    logic                  access_c;
    logic                  mem_we_c;
    logic                  unused_bits;

`ifdef DBUS_RESPONDER_STALL_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // Feedback taps for x^8+x^6+x^5+x^4+1
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
`endif

    // Address decode and byte-lane merge for the latched request
    always_comb begin
        off         = addr_q - BASE_ADDR;
        idx         = off[DEPTH_LOG2+2:3];
        in_range    = (addr_q >= BASE_ADDR) && (off[63:DEPTH_LOG2+3] == '0);
        old_word    = mem[idx];
        merged_word = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strobe_q[i]) begin
                merged_word[8*i +: 8] = data_q[8*i +: 8];
            end
        end
        rdata_c = in_range ? merged_word : 64'h0;
    end

    // The access happens on the last BUSY edge; reset on that edge cancels it
    assign access_c = (state == BUSY) && (cnt == '0);
    assign mem_we_c = access_c && !reset && in_range && (strobe_q != 8'h00);

    // Size only travels with the request; sub-word handling is the initiator's
    assign unused_bits = ^{size_q, off[2:0]};

    // Backing store: never reset, so contents survive a reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx] <= merged_word;
        end
    end

    // Request FSM: capture, count down, respond for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            data_q   <= '0;
            dresp    <= '0;
`ifdef DBUS_RESPONDER_STALL_EN
            lfsr     <= 8'hA5;
`endif
        end else begin
            case (state)
                IDLE: begin
                    dresp.addr_ok <= 1'b0;
                    dresp.data_ok <= 1'b0;
                    if (dreq.valid) begin
                        addr_q   <= dreq.addr;
                        size_q   <= dreq.size;
                        strobe_q <= dreq.strobe;
                        data_q   <= dreq.data;
`ifdef DBUS_RESPONDER_STALL_EN
                        cnt      <= CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
                        lfsr     <= {lfsr[6:0], lfsr_fb};
`else
                        cnt      <= CNT_W'(LATENCY - 1);
`endif
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        dresp.data    <= rdata_c;
                        dresp.addr_ok <= 1'b1;
                        dresp.data_ok <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    dresp.addr_ok <= 1'b0;
                    dresp.data_ok <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    dresp.addr_ok <= 1'b0;
                    dresp.data_ok <= 1'b0;
                    cnt           <= '0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized bench for dbus_responder against a word-addressed reference store.
// Honours DBUS_RESPONDER_STALL_EN by widening the latency window.

module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam int unsigned     LAT    = 2;
    localparam int unsigned     DL2    = 12;
    localparam logic [63:0]     BASE   = 64'h8000_0000;
    localparam longint unsigned NWORDS = longint'(1) << DL2;

    logic       clk;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [63:0] ref_mem [longint unsigned];

    dbus_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL2),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed view folded onto 8-byte words
    function automatic logic [63:0] ref_access(input logic [63:0] addr, input logic [7:0] strb,
                                               input logic [63:0] wd);
        logic [63:0]     w;
        longint unsigned widx;
        if (addr < BASE) return 64'h0;
        widx = longint'((addr - BASE) / 64'd8);
        if (widx >= NWORDS) return 64'h0;
        w = ref_mem.exists(widx) ? ref_mem[widx] : 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) w[8*i +: 8] = wd[8*i +: 8];
        end
        if (strb != 8'h00) ref_mem[widx] = w;
        return w;
    endfunction

    // Twelve known words: the first eight and the last four of the store
    function automatic logic [63:0] word_addr(input int k);
        if (k < 8) return BASE + 64'(8 * k);
        return BASE + 64'(8 * (int'(NWORDS) - 12 + k));
    endfunction

    function automatic logic [63:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
        if (r == 1) return BASE + 64'(NWORDS * 8) + 64'($urandom_range(0, 63));
        return word_addr(int'($urandom_range(0, 11))) + 64'($urandom_range(0, 7));
    endfunction

    task automatic check_lat(input string tag, input int got, input int nominal);
`ifdef DBUS_RESPONDER_STALL_EN
        check(tag, 64'((got >= nominal) && (got <= nominal + 3)), 64'd1);
`else
        check(tag, 64'(got), 64'(nominal));
`endif
    endtask

    task automatic do_reset(input string tag);
        dreq.valid = 1'b0;
        reset      = 1'b1;
        tick();
        check({tag, " addr_ok"}, 64'(dresp.addr_ok), 64'd0);
        check({tag, " data_ok"}, 64'(dresp.data_ok), 64'd0);
        check({tag, " data"}, dresp.data, 64'h0);
        tick();
        reset = 1'b0;
    endtask

    // One request; 'hold' keeps valid high with scrambled fields after capture
    task automatic do_txn(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] wd,
                          input bit hold, input string tag, output int lat, output int ok_cyc);
        logic [63:0] exp;
        bit          seen;
        exp         = ref_access(addr, strb, wd);
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'($urandom);
        dreq.strobe = strb;
        dreq.data   = wd;
        tick();
        dreq.valid  = hold;
        dreq.addr   = {$urandom, $urandom};
        dreq.strobe = 8'($urandom);
        dreq.data   = {$urandom, $urandom};
        lat  = 1;
        seen = dresp.data_ok;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            seen = dresp.data_ok;
        end
        ok_cyc = cyc;
        check({tag, " data_ok seen"}, 64'(seen), 64'd1);
        check_lat({tag, " latency"}, lat, int'(LAT) + 1);
        check({tag, " addr_ok"}, 64'(dresp.addr_ok), 64'd1);
        check({tag, " data"}, dresp.data, exp);
        tick();
        check({tag, " data_ok drop"}, 64'(dresp.data_ok), 64'd0);
        check({tag, " data hold"}, dresp.data, exp);
        dreq.valid = 1'b0;
    endtask

    initial begin
        int          lat;
        int          t1;
        int          t2;
        int          n_ok;
        int          lats_a [16];
        int          lats_b [16];
        logic [63:0] a;
        logic [7:0]  s;

        dreq  = '0;
        reset = 1'b1;
        tick();
        do_reset("reset");

        // Directed: full write, misaligned read, partial write, read-back
        do_txn(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, "wr_full", lat, t1);
        do_txn(64'h8000_0014, 8'h00, 64'h0, 1'b0, "rd_unaligned", lat, t1);
        check("rd_unaligned value", dresp.data, 64'h1122_3344_5566_7788);
        do_txn(64'h8000_0010, 8'h0C, 64'h0000_0000_AABB_0000, 1'b0, "wr_partial", lat, t1);
        do_txn(64'h8000_0010, 8'h00, 64'h0, 1'b0, "rd_partial", lat, t1);
        check("rd_partial value", dresp.data, 64'h1122_3344_AABB_7788);

        // Fill the remaining known words
        for (int k = 0; k < 12; k++) begin
            if (k != 2) do_txn(word_addr(k), 8'hFF, {$urandom, $urandom}, 1'b0, "preload", lat, t1);
        end

        // Below-base read returns zero with normal timing
        do_txn(64'h7FFF_FFF8, 8'h00, 64'h0, 1'b0, "rd_oob", lat, t1);
        check("rd_oob value", dresp.data, 64'h0);

        // Reset during BUSY cancels the write and suppresses data_ok
        dreq.valid  = 1'b1;
        dreq.addr   = word_addr(3);
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        dreq.valid = 1'b0;
        reset      = 1'b1;
        tick();
        check("abort data_ok", 64'(dresp.data_ok), 64'd0);
        check("abort data", dresp.data, 64'h0);
        reset = 1'b0;
        n_ok  = 0;
        for (int i = 0; i < int'(LAT) + 6; i++) begin
            tick();
            if (dresp.data_ok) n_ok++;
        end
        check("abort no response", 64'(n_ok), 64'd0);
        do_txn(word_addr(3), 8'h00, 64'h0, 1'b0, "rd_after_abort", lat, t1);

        // Valid held through RESP, new address presented in the following IDLE cycle
        do_txn(word_addr(5), 8'hF0, {$urandom, $urandom}, 1'b1, "b2b_first", lat, t1);
        do_txn(word_addr(9), 8'h00, 64'h0, 1'b0, "b2b_second", lat, t2);
        check_lat("b2b spacing", t2 - t1, int'(LAT) + 2);

        // Random mix of reads, partial/full writes and out-of-range accesses
        for (int i = 0; i < 40; i++) begin
            a = pick_addr();
            s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            do_txn(a, s, {$urandom, $urandom}, 1'($urandom), "random", lat, t1);
        end

        // Latency sequence after reset must repeat exactly
        do_reset("reset_seq_a");
        for (int i = 0; i < 16; i++) begin
            do_txn(word_addr(i % 12), 8'h00, 64'h0, 1'b0, "seq_a", lat, t1);
            lats_a[i] = lat;
        end
        do_reset("reset_seq_b");
        for (int i = 0; i < 16; i++) begin
            do_txn(word_addr(i % 12), 8'h00, 64'h0, 1'b0, "seq_b", lat, t1);
            lats_b[i] = lat;
        end
        for (int i = 0; i < 16; i++) begin
            check("seq repeat", 64'(lats_b[i]), 64'(lats_a[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
